fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage WISC pipeline.
- Keeps its own shadow copy of destination tags for the instructions in EX and MEM.
- Compares those tags against the decode-stage source registers.
- Registers the 5-bit forwarding control words that drive the execute-stage operand muxes, along with the load-use stall and bubble controls for the fetch/decode boundary.
- Sits beside the ID/EX pipeline register and advances with it.

Parameters:
NREG_W, 3, register-specifier width (8 GPRs; R0 is an ordinary register, not hardwired to zero)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset; the block is in reset while rst==0
memStall  input  1  global freeze from the memory system; holds all state
flush  input  1  taken branch/jump resolved in EX; squashes the instruction in ID
idRsA  input  3  ID source register for operand A
idRsAVld  input  1  operand A reads the register file
idRsB  input  3  ID source register for operand B (store-data register for ST/STU)
idRsBVld  input  1  operand B reads the register file
idIsStore  input  1  ID instruction is ST or STU
idRd  input  3  ID destination register
idRegWr  input  1  ID instruction writes the register file
idWbSel  input  2  ID writeback source: 00 addPC, 01 mem, 10 ALU, 11 imm8
fwCntrlA  output  5  EX forwarding control for operand A (registered)
fwCntrlB  output  5  EX forwarding control for operand B (registered)
stall  output  1  hold PC and IF/ID; combinational
bubble  output  1  the ID/EX register loads a NOP this cycle; combinational

Behaviour:
- Control word encoding, decided here and used by the execute stage:
  - bit3 = forward enable.
  - bit2 = source stage: 0 EX->EX, 1 MEM->EX.
  - bits1:0 = data source: 00 addPC, 01 mem, 10 ALU, 11 imm8.
  - bit4 (fwCntrlB only) = the forwarded value is store data rather than the ALU operand.
  - Bits not listed are 0.
- Internal state:
  - exTag = {vld, rd, wbSel}, describing the instruction currently in EX.
  - memTag, the same fields for the instruction currently in MEM.
  - Registered fwCntrlA and fwCntrlB.
- Reset (rst==0): exTag.vld=0, memTag.vld=0, fwCntrlA=5'b0, fwCntrlB=5'b0. stall and bubble evaluate to 0.
- Match rule: an operand hits stage S when its Vld=1, S.vld=1 and S.rd equals the operand register.
- Per-operand selection, evaluated in ID, first matching rule wins:
  - Operand hits exTag with wbSel==01: load-use hazard, so no forward is encoded and stall is raised.
  - Operand hits exTag with any other wbSel: {0,1,0,wbSel}. The EX hit takes priority because it is the youngest writer.
  - Operand hits memTag: {0,1,1,wbSel}.
  - Otherwise 5'b0.
  - For operand B with idIsStore=1, bit4 is additionally set whenever bit3 is set.
- stall = hazard on A or hazard on B, and flush==0.
- bubble = stall or flush.
- Clock edge with memStall=1: no state changes.
- Clock edge otherwise:
  - memTag <= exTag.
  - If bubble: exTag.vld <= 0 and fwCntrlA/fwCntrlB <= 0.
  - Else: exTag <= {idRegWr, idRd, idWbSel}, and fwCntrl* <= the computed words.
- Latency: the control words are valid during the cycle the consuming instruction is in EX, one edge after decode.
- A load-use hazard costs exactly one stall cycle. On the next cycle the load is in MEM, so the MEM->EX mem forward (x101) applies.
- flush together with a hazard: flush wins, and stall is 0 so fetch redirects.
- flush together with memStall: nothing changes; flush is honoured on the first unstalled edge.
- Asynchronous reset mid-operation clears all tags immediately, with no clock edge needed. No stale forward may appear after reset is released.

Decomposition:
- Shared package fwd_pkg holds:
  - the WB_ADDPC/WB_MEM/WB_ALU/WB_IMM8 codes;
  - the FW_EN, FW_MEM, FW_ST bit positions;
  - the 5-bit control-word constants.
- One sub-module, fwd_sel: combinational per-operand selector, instantiated twice (A, B).

Test Plan:
- ADD R3 then SUB using R3 as A -> EX cycle of SUB sees fwCntrlA=5'b01010 and stall is never raised.
- LD R2, then an unrelated instruction, then ADD R2 as B -> fwCntrlB=5'b01101 with no stall. Back-to-back LD R2 then ADD R2 -> exactly one cycle of stall=1 and bubble=1, then fwCntrlB=5'b01101.
- R5 written by both MEM (ALU result) and EX (LBI, imm8), consumer reads R5 on A -> fwCntrlA=5'b01011, proving EX priority.
- ST whose store-data register R4 was produced by the preceding ALU op -> fwCntrlB=5'b11010.
- LD R1 followed by a dependent ADD with flush=1 in the same cycle -> stall=0, bubble=1, and fwCntrl* next cycle = 0.
- Drive rst low in the middle of a dependent sequence, then release it -> outputs are 0 and the first post-reset consumer gets no forward.

Source files
------------

// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the WISC forwarding / hazard controller.
//   - writeback-source codes (idWbSel / tag wbSel field)
//   - bit positions inside the 5-bit forwarding control word
//   - named control-word constants and a helper that builds a forward word
// ---------------------------------------------------------------------------
package fwd_pkg;

   // Writeback source of an instruction
   localparam logic [1:0] WB_ADDPC = 2'b00;
   localparam logic [1:0] WB_MEM   = 2'b01;
   localparam logic [1:0] WB_ALU   = 2'b10;
   localparam logic [1:0] WB_IMM8  = 2'b11;

   // Control word bit positions; bits 1:0 carry the data source (WB_* code)
   localparam int FW_ST  = 4;   // forwarded value is store data (operand B only)
   localparam int FW_EN  = 3;   // forward enable
   localparam int FW_MEM = 2;   // 0: EX->EX, 1: MEM->EX

   // Frequently used control words
   localparam logic [4:0] FW_NONE      = 5'b00000;
   localparam logic [4:0] FW_EX_ALU    = 5'b01010;
   localparam logic [4:0] FW_EX_IMM8   = 5'b01011;
   localparam logic [4:0] FW_MEM_MEM   = 5'b01101;
   localparam logic [4:0] FW_ST_EX_ALU = 5'b11010;

   // Build an enabled forward word from the producing stage and its wb source
   function automatic logic [4:0] fw_word(input logic from_mem, input logic [1:0] wb_sel);
      logic [4:0] w;
      w         = FW_NONE;
      w[FW_EN]  = 1'b1;
      w[FW_MEM] = from_mem;
      w[1:0]    = wb_sel;
      return w;
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Decode-side bundle between the pipeline and the forwarding controller.
//   master : pipeline side, drives the decode info / memStall / flush and
//            consumes the forwarding words and stall/bubble
//   slave  : the controller
// ---------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
   parameter int NREG_W = 3
);
   logic              memStall;
   logic              flush;
   logic [NREG_W-1:0] idRsA;
   logic              idRsAVld;
   logic [NREG_W-1:0] idRsB;
   logic              idRsBVld;
   logic              idIsStore;
   logic [NREG_W-1:0] idRd;
   logic              idRegWr;
   logic [1:0]        idWbSel;
   logic [4:0]        fwCntrlA;
   logic [4:0]        fwCntrlB;
   logic              stall;
   logic              bubble;

   modport master (
      output memStall, flush, idRsA, idRsAVld, idRsB, idRsBVld,
             idIsStore, idRd, idRegWr, idWbSel,
      input  fwCntrlA, fwCntrlB, stall, bubble
   );

   modport slave (
      input  memStall, flush, idRsA, idRsAVld, idRsB, idRsBVld,
             idIsStore, idRd, idRegWr, idWbSel,
      output fwCntrlA, fwCntrlB, stall, bubble
   );
endinterface

// File: rtl/fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Combinational forwarding selector for one decode-stage source operand.
//   rs_i/rs_vld_i   : source register and its read-enable
//   is_store_i      : operand is store data (sets the store bit on a forward)
//   ex_* / mem_*    : destination tags of the instructions in EX and MEM
//   fw_o            : forwarding control word for this operand
//   hazard_o        : load-use hazard (EX holds a load writing this register)
// ---------------------------------------------------------------------------
module fwd_sel
   import fwd_pkg::*;
#(
   parameter int NREG_W = 3
) (
   input  logic [NREG_W-1:0] rs_i,
   input  logic              rs_vld_i,
   input  logic              is_store_i,
   input  logic              ex_vld_i,
   input  logic [NREG_W-1:0] ex_rd_i,
   input  logic [1:0]        ex_wb_i,
   input  logic              mem_vld_i,
   input  logic [NREG_W-1:0] mem_rd_i,
   input  logic [1:0]        mem_wb_i,
   output logic [4:0]        fw_o,
   output logic              hazard_o
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = rs_vld_i && ex_vld_i  && (ex_rd_i  == rs_i);
   assign mem_hit = rs_vld_i && mem_vld_i && (mem_rd_i == rs_i);

   always_comb begin
      fw_o     = FW_NONE;
      hazard_o = 1'b0;
      // EX is the youngest writer, so it shadows a MEM match even when the
      // EX instruction is a load that cannot forward yet.
      if (ex_hit) begin
         if (ex_wb_i == WB_MEM) begin
            hazard_o = 1'b1;
         end else begin
            fw_o = fw_word(1'b0, ex_wb_i);
         end
      end else if (mem_hit) begin
         fw_o = fw_word(1'b1, mem_wb_i);
      end
      if (is_store_i && fw_o[FW_EN]) begin
         fw_o[FW_ST] = 1'b1;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller for the 5-stage WISC pipeline.
// Tracks destination tags of the EX and MEM instructions, compares them with
// the decode-stage sources and registers the forwarding words consumed in EX.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : decode info, memStall, flush in; fwCntrlA/B (registered),
//          stall and bubble (combinational) out
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int NREG_W = 3
) (
   input logic              clk,
   input logic              rst,
   fwd_hazard_ctrl_if.slave bus
);

   // Shadow tags for the instructions in EX and MEM
   logic              ex_vld_q,  ex_vld_d;
   logic [NREG_W-1:0] ex_rd_q,   ex_rd_d;
   logic [1:0]        ex_wb_q,   ex_wb_d;
   logic              mem_vld_q, mem_vld_d;
   logic [NREG_W-1:0] mem_rd_q,  mem_rd_d;
   logic [1:0]        mem_wb_q,  mem_wb_d;
   logic [4:0]        fw_a_q,    fw_a_d;
   logic [4:0]        fw_b_q,    fw_b_d;

   logic [4:0] fw_a_sel;
   logic [4:0] fw_b_sel;
   logic       haz_a;
   logic       haz_b;
   logic       stall;
   logic       bubble;

   fwd_sel #(.NREG_W(NREG_W)) u_sel_a (
      .rs_i      (bus.idRsA),
      .rs_vld_i  (bus.idRsAVld),
      .is_store_i(1'b0),
      .ex_vld_i  (ex_vld_q),
      .ex_rd_i   (ex_rd_q),
      .ex_wb_i   (ex_wb_q),
      .mem_vld_i (mem_vld_q),
      .mem_rd_i  (mem_rd_q),
      .mem_wb_i  (mem_wb_q),
      .fw_o      (fw_a_sel),
      .hazard_o  (haz_a)
   );

   fwd_sel #(.NREG_W(NREG_W)) u_sel_b (
      .rs_i      (bus.idRsB),
      .rs_vld_i  (bus.idRsBVld),
      .is_store_i(bus.idIsStore),
      .ex_vld_i  (ex_vld_q),
      .ex_rd_i   (ex_rd_q),
      .ex_wb_i   (ex_wb_q),
      .mem_vld_i (mem_vld_q),
      .mem_rd_i  (mem_rd_q),
      .mem_wb_i  (mem_wb_q),
      .fw_o      (fw_b_sel),
      .hazard_o  (haz_b)
   );

   // A flush kills the stalled instruction anyway, so fetch must be free to
   // redirect. Both controls are held low while the block is in reset.
   assign stall  = (haz_a || haz_b) && !bus.flush;
   assign bubble = (stall || bus.flush) && rst;

   assign bus.stall    = stall;
   assign bus.bubble   = bubble;
   assign bus.fwCntrlA = fw_a_q;
   assign bus.fwCntrlB = fw_b_q;

   always_comb begin
      ex_vld_d  = ex_vld_q;
      ex_rd_d   = ex_rd_q;
      ex_wb_d   = ex_wb_q;
      mem_vld_d = mem_vld_q;
      mem_rd_d  = mem_rd_q;
      mem_wb_d  = mem_wb_q;
      fw_a_d    = fw_a_q;
      fw_b_d    = fw_b_q;
      // memStall freezes everything, including a pending flush
      if (!bus.memStall) begin
         mem_vld_d = ex_vld_q;
         mem_rd_d  = ex_rd_q;
         mem_wb_d  = ex_wb_q;
         if (bubble) begin
            ex_vld_d = 1'b0;
            fw_a_d   = FW_NONE;
            fw_b_d   = FW_NONE;
         end else begin
            ex_vld_d = bus.idRegWr;
            ex_rd_d  = bus.idRd;
            ex_wb_d  = bus.idWbSel;
            fw_a_d   = fw_a_sel;
            fw_b_d   = fw_b_sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_vld_q  <= 1'b0;
         ex_rd_q   <= '0;
         ex_wb_q   <= WB_ADDPC;
         mem_vld_q <= 1'b0;
         mem_rd_q  <= '0;
         mem_wb_q  <= WB_ADDPC;
         fw_a_q    <= FW_NONE;
         fw_b_q    <= FW_NONE;
      end else begin
         ex_vld_q  <= ex_vld_d;
         ex_rd_q   <= ex_rd_d;
         ex_wb_q   <= ex_wb_d;
         mem_vld_q <= mem_vld_d;
         mem_rd_q  <= mem_rd_d;
         mem_wb_q  <= mem_wb_d;
         fw_a_q    <= fw_a_d;
         fw_b_q    <= fw_b_d;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Directed scenarios followed by random traffic, all checked against a model
// that tracks which instruction occupies EX and MEM.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

   logic clk;
   logic rst;

   fwd_hazard_ctrl_if #(.NREG_W(3)) bus ();

   fwd_hazard_ctrl #(.NREG_W(3)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the instruction records sitting in EX and MEM
   typedef struct {
      bit       vld;
      bit [2:0] rd;
      bit [1:0] wb;
   } ins_t;

   ins_t       in_ex;
   ins_t       in_mem;
   logic [4:0] m_fwA;
   logic [4:0] m_fwB;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %b expected %b", tag, obs, exp);
         $error("check %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      in_ex  = '{vld: 1'b0, rd: 3'd0, wb: 2'd0};
      in_mem = '{vld: 1'b0, rd: 3'd0, wb: 2'd0};
      m_fwA  = 5'd0;
      m_fwB  = 5'd0;
   endtask

   // Youngest matching writer decides; a load still in EX cannot forward.
   // Word value = enable(8) + 4*stage(0 EX, 1 MEM) + wb code, +16 for store data.
   task automatic model_sel(input bit [2:0] rs, input bit v, input bit st,
                            output logic [4:0] w, output bit haz);
      int val;
      val = 0;
      haz = 1'b0;
      if (v) begin
         if (in_ex.vld && in_ex.rd == rs) begin
            if (in_ex.wb == 2'd1) haz = 1'b1;
            else                  val = 8 + int'(in_ex.wb);
         end else if (in_mem.vld && in_mem.rd == rs) begin
            val = 8 + 4 + int'(in_mem.wb);
         end
         if (st && val != 0) val += 16;
      end
      w = 5'(val);
   endtask

   task automatic drive(input bit [2:0] ra, input bit av, input bit [2:0] rb, input bit bv,
                        input bit st, input bit [2:0] rd, input bit wr, input bit [1:0] wb,
                        input bit fl, input bit ms);
      bus.idRsA     = ra;
      bus.idRsAVld  = av;
      bus.idRsB     = rb;
      bus.idRsBVld  = bv;
      bus.idIsStore = st;
      bus.idRd      = rd;
      bus.idRegWr   = wr;
      bus.idWbSel   = wb;
      bus.flush     = fl;
      bus.memStall  = ms;
   endtask

   // Check the current cycle against the model, then cross one rising edge
   task automatic tick(input string tag);
      logic [4:0] wa, wbw;
      bit ha, hb, e_stall, e_bubble;
      #1;
      model_sel(bus.idRsA, bus.idRsAVld, 1'b0, wa, ha);
      model_sel(bus.idRsB, bus.idRsBVld, bus.idIsStore, wbw, hb);
      e_stall  = (ha || hb) && !bus.flush;
      e_bubble = e_stall || bus.flush;
      check({tag, ".stall"},  {4'd0, bus.stall},  {4'd0, e_stall});
      check({tag, ".bubble"}, {4'd0, bus.bubble}, {4'd0, e_bubble});
      check({tag, ".fwA"},    bus.fwCntrlA, m_fwA);
      check({tag, ".fwB"},    bus.fwCntrlB, m_fwB);
      $display("[%0t] %s A=%0d/%0b B=%0d/%0b st=%0b rd=%0d wr=%0b wb=%0d fl=%0b ms=%0b | fwA=%b fwB=%b stall=%0b bubble=%0b",
               $time, tag, bus.idRsA, bus.idRsAVld, bus.idRsB, bus.idRsBVld, bus.idIsStore,
               bus.idRd, bus.idRegWr, bus.idWbSel, bus.flush, bus.memStall,
               bus.fwCntrlA, bus.fwCntrlB, bus.stall, bus.bubble);
      @(posedge clk);
      if (!bus.memStall) begin
         in_mem = in_ex;
         if (e_bubble) begin
            in_ex.vld = 1'b0;
            m_fwA     = 5'd0;
            m_fwB     = 5'd0;
         end else begin
            in_ex = '{vld: bus.idRegWr, rd: bus.idRd, wb: bus.idWbSel};
            m_fwA = wa;
            m_fwB = wbw;
         end
      end
      #1;
   endtask

   initial begin
      model_reset();
      rst = 1'b0;
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("reset.fwA",    bus.fwCntrlA, 5'b00000);
      check("reset.fwB",    bus.fwCntrlB, 5'b00000);
      check("reset.stall",  {4'd0, bus.stall},  5'd0);
      check("reset.bubble", {4'd0, bus.bubble}, 5'd0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // ADD R3 ; SUB uses R3 as A -> EX->EX ALU forward, no stall
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 2'b10, 1'b0, 1'b0); tick("add_r3");
      drive(3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 2'b10, 1'b0, 1'b0);
      #1 check("sub.stall", {4'd0, bus.stall}, 5'd0);
      tick("sub_r3");
      check("sub.fwA", bus.fwCntrlA, 5'b01010);

      // LD R2 ; unrelated ; ADD R2 as B -> MEM->EX mem forward
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 2'b01, 1'b0, 1'b0); tick("ld_r2");
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b1, 2'b10, 1'b0, 1'b0); tick("unrel");
      drive(3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd6, 1'b1, 2'b10, 1'b0, 1'b0);
      #1 check("gap.stall", {4'd0, bus.stall}, 5'd0);
      tick("add_r2");
      check("gap.fwB", bus.fwCntrlB, 5'b01101);

      // Back-to-back LD R2 ; ADD R2 -> one stall cycle then mem forward
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 2'b01, 1'b0, 1'b0); tick("ld_r2b");
      drive(3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd6, 1'b1, 2'b10, 1'b0, 1'b0);
      #1 check("lu.stall1",  {4'd0, bus.stall},  5'd1);
      check("lu.bubble1", {4'd0, bus.bubble}, 5'd1);
      tick("add_r2_stall");
      check("lu.stall2", {4'd0, bus.stall}, 5'd0);
      tick("add_r2_go");
      check("lu.fwB", bus.fwCntrlB, 5'b01101);

      // ALU R5 ; LBI R5 ; consumer A=R5 -> EX imm8 wins over MEM
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 2'b10, 1'b0, 1'b0); tick("alu_r5");
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 2'b11, 1'b0, 1'b0); tick("lbi_r5");
      drive(3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 2'b10, 1'b0, 1'b0); tick("use_r5");
      check("prio.fwA", bus.fwCntrlA, 5'b01011);

      // ALU R4 ; ST with data R4 -> store-data forward
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 2'b10, 1'b0, 1'b0); tick("alu_r4");
      drive(3'd1, 1'b0, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0); tick("st_r4");
      check("st.fwB", bus.fwCntrlB, 5'b11010);

      // LD R1 ; dependent ADD with flush -> flush wins
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 2'b01, 1'b0, 1'b0); tick("ld_r1");
      drive(3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 2'b10, 1'b1, 1'b0);
      #1 check("fl.stall",  {4'd0, bus.stall},  5'd0);
      check("fl.bubble", {4'd0, bus.bubble}, 5'd1);
      tick("add_r1_flush");
      check("fl.fwA", bus.fwCntrlA, 5'b00000);
      check("fl.fwB", bus.fwCntrlB, 5'b00000);
      drive(3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 2'b10, 1'b0, 1'b0); tick("add_r1_after");
      check("fl.memfw", bus.fwCntrlA, 5'b01101);

      // flush + memStall holds everything; flush honoured afterwards
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b1, 2'b01, 1'b0, 1'b0); tick("ld_r7");
      drive(3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 2'b10, 1'b1, 1'b1); tick("fl_ms1");
      tick("fl_ms2");
      drive(3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 2'b10, 1'b1, 1'b0); tick("fl_go");
      check("flms.fwA", bus.fwCntrlA, 5'b00000);

      // Async reset in the middle of a dependent sequence
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 2'b10, 1'b0, 1'b0); tick("alu_r3_pre");
      drive(3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd6, 1'b1, 2'b10, 1'b0, 1'b0); tick("use_r3_pre");
      drive(3'd6, 1'b1, 3'd3, 1'b1, 1'b0, 3'd2, 1'b1, 2'b10, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("arst.fwA",    bus.fwCntrlA, 5'b00000);
      check("arst.fwB",    bus.fwCntrlB, 5'b00000);
      check("arst.stall",  {4'd0, bus.stall},  5'd0);
      check("arst.bubble", {4'd0, bus.bubble}, 5'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      tick("post_rst_use");
      check("post.fwA", bus.fwCntrlA, 5'b00000);
      check("post.fwB", bus.fwCntrlB, 5'b00000);

      // Random traffic over a small register set to provoke hits
      for (int i = 0; i < 300; i++) begin
         drive(3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
               2'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
         tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
